// File: rtl/vram_arbiter_if.sv
// Bundle of the display fetch, CPU port and RAM signals around vram_arbiter.
// The arbiter takes the slave view; whatever drives the display, CPU and RAM takes the master view.
interface vram_arbiter_if #(
  parameter int RamBits = 16
);
  logic               dispReq;
  logic [RamBits-1:0] dispAddr;
  logic               cpuReq;
  logic               cpuWe;
  logic [RamBits-1:0] cpuAddr;
  logic [7:0]         cpuWData;
  logic               cpuReady;
  logic               cpuRValid;
  logic [7:0]         cpuRData;
  logic               cpuStarved;
  logic [RamBits-1:0] ramAddr;
  logic               ramWe;
  logic [7:0]         ramDataOut;
  logic [7:0]         ramDataIn;

  modport slave (
    input  dispReq, dispAddr, cpuReq, cpuWe, cpuAddr, cpuWData, ramDataIn,
    output cpuReady, cpuRValid, cpuRData, cpuStarved, ramAddr, ramWe, ramDataOut
  );

  modport master (
    output dispReq, dispAddr, cpuReq, cpuWe, cpuAddr, cpuWData, ramDataIn,
    input  cpuReady, cpuRValid, cpuRData, cpuStarved, ramAddr, ramWe, ramDataOut
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares single-port VRAM between display fetch (absolute priority) and a queued CPU port.
// CPU accesses go through a small in-order FIFO and use only the cycles the display leaves free.
module vram_arbiter #(
  parameter int RamBits     = 16,
  parameter int Depth       = 2,
  parameter int StarveLimit = 64
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);
  localparam int IdxW = $clog2(Depth);
  localparam int PtrW = IdxW + 1;
  localparam int CntW = $clog2(StarveLimit + 1);
  localparam logic [PtrW-1:0] FullDiff = {1'b1, {IdxW{1'b0}}};
  localparam logic [CntW-1:0] LimitVal = CntW'(StarveLimit);

  logic               memWe_q   [Depth];
  logic [RamBits-1:0] memAddr_q [Depth];
  logic [7:0]         memData_q [Depth];

  logic [PtrW-1:0] wrPtr_q, wrPtr_d;
  logic [PtrW-1:0] rdPtr_q, rdPtr_d;
  logic            rdPending_q, rdPending_d;
  logic            cpuRValid_q, cpuRValid_d;
  logic [7:0]      cpuRData_q, cpuRData_d;
  logic [CntW-1:0] waitCnt_q, waitCnt_d;

  logic            empty;
  logic            full;
  logic            push;
  logic            grant;
  logic [IdxW-1:0] wrIdx;
  logic [IdxW-1:0] rdIdx;

  assign wrIdx = wrPtr_q[IdxW-1:0];
  assign rdIdx = rdPtr_q[IdxW-1:0];
  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = ((wrPtr_q ^ rdPtr_q) == FullDiff);
  assign push  = bus.cpuReq && !full;
  assign grant = !bus.dispReq && !empty;

  assign bus.cpuReady   = !full;
  assign bus.cpuRValid  = cpuRValid_q;
  assign bus.cpuRData   = cpuRData_q;
  assign bus.cpuStarved = (waitCnt_q == LimitVal);

  // RAM mux is purely combinational so display fetch keeps its exact address timing.
  always_comb begin
    bus.ramAddr    = '0;
    bus.ramWe      = 1'b0;
    bus.ramDataOut = memData_q[rdIdx];
    if (bus.dispReq) begin
      bus.ramAddr = bus.dispAddr;
    end else if (!empty) begin
      bus.ramAddr = memAddr_q[rdIdx];
      bus.ramWe   = memWe_q[rdIdx];
    end
  end

  always_comb begin
    wrPtr_d     = wrPtr_q + PtrW'(push);
    rdPtr_d     = rdPtr_q + PtrW'(grant);
    rdPending_d = grant && !memWe_q[rdIdx];
    cpuRValid_d = rdPending_q;
    cpuRData_d  = rdPending_q ? bus.ramDataIn : cpuRData_q;
    waitCnt_d   = waitCnt_q;
    // A non-empty FIFO without a grant can only mean the display holds the RAM.
    if (empty || grant) begin
      waitCnt_d = '0;
    end else if (waitCnt_q != LimitVal) begin
      waitCnt_d = waitCnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      rdPending_q <= 1'b0;
      cpuRValid_q <= 1'b0;
      cpuRData_q  <= '0;
      waitCnt_q   <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      rdPending_q <= rdPending_d;
      cpuRValid_q <= cpuRValid_d;
      cpuRData_q  <= cpuRData_d;
      waitCnt_q   <= waitCnt_d;
    end
  end

  // Entry storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      memWe_q[wrIdx]   <= bus.cpuWe;
      memAddr_q[wrIdx] <= bus.cpuAddr;
      memData_q[wrIdx] <= bus.cpuWData;
    end
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the VDP's single-port video RAM between the display fetch pipeline and the CPU bus port. Display fetch has absolute priority and keeps its existing cycle-exact address timing. CPU accesses are queued in a small in-order FIFO and issued in cycles where display fetch does not need the RAM. The block sits between the VDP fetch logic, the CPU-side port decoder and the `Ram` instance.

## Interface
- `RamBits`, 16: VRAM address width (64 KB default).
- `Depth`, 2: CPU request FIFO depth; power of two, ≥ 2.
- `StarveLimit`, 64: consecutive blocked cycles after which `cpuStarved` asserts.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  reset, asynchronous, active-high
- `dispReq`  in  1  display fetch needs the RAM this cycle
- `dispAddr`  in  RamBits  display fetch address
- `cpuReq`  in  1  CPU request strobe; accepted when `cpuReady` is also high
- `cpuWe`  in  1  1 = write, 0 = read (sampled with `cpuReq`)
- `cpuAddr`  in  RamBits  CPU address
- `cpuWData`  in  8  CPU write data
- `cpuReady`  out  1  FIFO not full
- `cpuRValid`  out  1  one-cycle pulse, `cpuRData` valid
- `cpuRData`  out  8  read result
- `cpuStarved`  out  1  head request blocked ≥ StarveLimit cycles
- `ramAddr`  out  RamBits  to RAM address
- `ramWe`  out  1  to RAM write enable
- `ramDataOut`  out  8  to RAM write data
- `ramDataIn`  in  8  from RAM read data; valid the cycle after the address is presented

## Operation
- RAM mux is combinational:
  - If `dispReq` = 1: `ramAddr` = `dispAddr`, `ramWe` = 0.
  - Else, if the FIFO is non-empty: `ramAddr`/`ramWe`/`ramDataOut` come from the FIFO head (a grant).
  - Else: `ramAddr` = 0, `ramWe` = 0.
- `ramDataOut` always carries the head's write data; it is a don't-care when `ramWe` = 0.
- FIFO:
  - `Depth` entries of {we, addr, wdata}; read and write pointers are log2(Depth)+1 bits.
  - Full when the pointers differ only in the MSB.
  - Push on `cpuReq & cpuReady`. Pop at the end of every grant cycle.
  - No bypass: a request pushed into an empty FIFO is first granted the following cycle.
  - Push and pop in the same cycle are both performed; the count is unchanged.
  - `cpuReady` is derived from the count at the start of the cycle. A pop in the same cycle does not free a slot for that cycle's push.
- Read completion:
  - A read grant sets `rdPending`.
  - On the next cycle, `ramDataIn` is registered into `cpuRData` and `rdPending` clears.
  - `cpuRValid` pulses in the cycle after that.
  - Reads return strictly in issue order. Writes give no completion signal.
- Ordering: all CPU accesses complete in acceptance order, so a read after a write to the same address returns the new data.
- Starvation:
  - `waitCnt` increments (saturating at StarveLimit) in each cycle where the FIFO is non-empty and `dispReq` = 1.
  - It clears on any grant or when the FIFO is empty.
  - `cpuStarved` = (`waitCnt` == StarveLimit).
  - The display is never stalled.

## Timing
- Reset values:
  - `cpuReady` = 1; `cpuRValid` = 0; `cpuRData` = 0; `cpuStarved` = 0.
  - `ramWe` = 0 and `ramAddr` = 0, since the FIFO is empty.
  - `rdPending` = 0; pointers = 0; `waitCnt` = 0.
- Latency with `dispReq` idle:
  - Write accepted at edge N reaches the RAM at edge N+1.
  - Read accepted at edge N: grant in cycle N+1, data on `ramDataIn` in cycle N+2, `cpuRValid` high in cycle N+3.
- Back-to-back CPU accesses sustain one grant per cycle while `dispReq` = 0.
- In display modes that fetch every other cycle, the CPU gets at most one grant per two cycles.
- Reset asserted mid-operation:
  - The FIFO is flushed and the in-flight read is dropped.
  - `cpuRValid` must not pulse for requests issued before reset.
  - `ramWe` falls immediately, since reset is asynchronous and the FIFO becomes empty.
- `dispReq` rising in the same cycle a request sits at the FIFO head: the display wins and the head stays queued.

## Test plan
- Idle display:
  - Stimulus: write 0x5A to 0x1234, then read 0x1234.
  - Required: `ramWe` high for exactly one cycle with `ramAddr` = 0x1234; `cpuRValid` pulses 3 cycles after the read is accepted, with `cpuRData` = 0x5A.
- Fill:
  - Stimulus: `dispReq` held high; push 2 writes.
  - Required: `cpuReady` = 0 after the second push; a third `cpuReq` is ignored; after `dispReq` drops, both writes issue on consecutive cycles, in order.
- Alternating display:
  - Stimulus: `dispReq` toggling 1,0,1,0; 4 queued reads of addresses 0x0000, 0x0001, 0x0002, 0x0003.
  - Required: grants only in `dispReq` = 0 cycles; `ramAddr` equals `dispAddr` in every `dispReq` = 1 cycle; 4 in-order `cpuRValid` pulses.
- Starvation:
  - Stimulus: `dispReq` held high for 70 cycles with one queued write.
  - Required: `cpuStarved` rises exactly 64 cycles after the push and clears the cycle after the grant.
- Reset mid-read:
  - Stimulus: assert reset in the cycle after a read grant.
  - Required: no `cpuRValid` pulse; after release, `cpuReady` = 1, `ramWe` = 0, and the FIFO is empty.
- Simultaneous push and pop with the FIFO full:
  - Required: the push is rejected that cycle and accepted the next.
